// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle RV32I-subset control FSM (optional perf counters: CPU_CTRL_PERF_EN)
module cpu_ctrl_fsm #(
  parameter int DATAWIDTH  = 32,
  parameter bit RESET_HALT = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  input  logic [DATAWIDTH-1:0] instr_i,
  input  logic                 eq_i,
  input  logic                 lt_i,
  output logic                 imem_re_o,
  output logic                 ir_en_o,
  output logic                 rf_re_o,
  output logic                 rf_we_o,
  output logic [1:0]           wb_sel_o,
  output logic [3:0]           alu_op_o,
  output logic                 alu_b_imm_o,
  output logic                 dmem_re_o,
  output logic                 dmem_we_o,
  output logic                 pc_en_o,
  output logic                 pc_sel_o,
  output logic                 halt_o,
  output logic                 illegal_o,
  output logic [2:0]           state_o
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [31:0]          cycle_cnt_o,
  output logic [31:0]          instret_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [DATAWIDTH-1:0] EBREAK = DATAWIDTH'(32'h0010_0073);

  state_t               state, state_nx;
  logic [DATAWIDTH-1:0] ir;
  logic                 illegal, illegal_set, illegal_clr;
  logic [6:0]           opc;
  logic [2:0]           f3;
  logic                 br_ok, taken;
  logic [3:0]           alu_op_dec;
  logic                 b_imm_dec;

  logic imem_re, ir_en, rf_re, rf_we, alu_b_imm, dmem_re, dmem_we, pc_en, pc_sel, halt;
  logic [1:0] wb_sel;
  logic [3:0] alu_op;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];

  // Branch condition and ALU control decoded from the held instruction
  always_comb begin
    br_ok      = 1'b1;
    taken      = 1'b0;
    alu_op_dec = 4'b0000;
    b_imm_dec  = 1'b0;
    case (f3)
      3'b000:  taken = eq_i;
      3'b001:  taken = ~eq_i;
      3'b100:  taken = lt_i;
      3'b101:  taken = ~lt_i;
      default: br_ok = 1'b0;
    endcase
    case (opc)
      OPC_OP:    alu_op_dec = {ir[30], f3};
      OPC_OPIMM: begin
        alu_op_dec = {(f3 == 3'b101) & ir[30], f3};
        b_imm_dec  = 1'b1;
      end
      OPC_LOAD, OPC_STORE, OPC_JAL: b_imm_dec = 1'b1;
      default: ;
    endcase
  end

  // State register; reset drops any in-flight instruction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= RESET_HALT ? S_HALT : S_FETCH;
    else       state <= state_nx;
  end

  // Instruction register and sticky illegal flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      if (ir_en) ir <= instr_i;
      if (illegal_set)      illegal <= 1'b1;
      else if (illegal_clr) illegal <= 1'b0;
    end
  end

  // Next-state and control outputs; ALU control held through MEM/WB for address and target
  always_comb begin
    state_nx    = state;
    imem_re     = 1'b0;
    ir_en       = 1'b0;
    rf_re       = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 2'b00;
    alu_op      = 4'b0000;
    alu_b_imm   = 1'b0;
    dmem_re     = 1'b0;
    dmem_we     = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    halt        = 1'b0;
    illegal_set = 1'b0;
    illegal_clr = 1'b0;
    case (state)
      S_FETCH: begin
        imem_re  = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        ir_en    = 1'b1;
        rf_re    = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        alu_op    = alu_op_dec;
        alu_b_imm = b_imm_dec;
        case (opc)
          OPC_OP, OPC_OPIMM, OPC_JAL: state_nx = S_WB;
          OPC_LOAD, OPC_STORE:        state_nx = S_MEM;
          OPC_BRANCH: begin
            if (br_ok) begin
              pc_en    = 1'b1;
              pc_sel   = taken;
              state_nx = S_FETCH;
            end else begin
              illegal_set = 1'b1;
              state_nx    = S_HALT;
            end
          end
          OPC_SYSTEM: begin
            illegal_set = (ir != EBREAK);
            state_nx    = S_HALT;
          end
          default: begin
            illegal_set = 1'b1;
            state_nx    = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        alu_op    = alu_op_dec;
        alu_b_imm = b_imm_dec;
        if (opc == OPC_STORE) begin
          dmem_we  = 1'b1;
          pc_en    = 1'b1;
          state_nx = S_FETCH;
        end else begin
          dmem_re  = 1'b1;
          state_nx = S_WB;
        end
      end
      S_WB: begin
        alu_op    = alu_op_dec;
        alu_b_imm = b_imm_dec;
        rf_we     = (ir[11:7] != 5'd0);
        pc_en     = 1'b1;
        if (opc == OPC_LOAD) begin
          wb_sel = 2'b01;
        end else if (opc == OPC_JAL) begin
          wb_sel = 2'b10;
          pc_sel = 1'b1;
        end
        state_nx = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
        if (run_i) begin
          illegal_clr = 1'b1;
          state_nx    = S_FETCH;
        end
      end
      default: state_nx = S_HALT;
    endcase
  end

  // Controls are forced low while reset is held so nothing fires during reset
  assign imem_re_o   = imem_re & ~rst_i;
  assign ir_en_o     = ir_en & ~rst_i;
  assign rf_re_o     = rf_re & ~rst_i;
  assign rf_we_o     = rf_we & ~rst_i;
  assign wb_sel_o    = rst_i ? 2'b00 : wb_sel;
  assign alu_op_o    = rst_i ? 4'b0000 : alu_op;
  assign alu_b_imm_o = alu_b_imm & ~rst_i;
  assign dmem_re_o   = dmem_re & ~rst_i;
  assign dmem_we_o   = dmem_we & ~rst_i;
  assign pc_en_o     = pc_en & ~rst_i;
  assign pc_sel_o    = pc_sel & ~rst_i;
  assign halt_o      = halt;
  assign illegal_o   = illegal;
  assign state_o     = state;

`ifdef CPU_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;

  // Active-cycle and retired-instruction counters, frozen in HALT
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt   <= cycle_cnt + 32'd1;
      if (pc_en)           instret_cnt <= instret_cnt + 32'd1;
    end
  end

  assign cycle_cnt_o   = cycle_cnt;
  assign instret_cnt_o = instret_cnt;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - randomized self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst, run, eq, lt;
  logic [31:0] instr;
  logic        imem_re, ir_en, rf_re, rf_we, alu_b_imm, dmem_re, dmem_we, pc_en, pc_sel, halt, illegal;
  logic [1:0]  wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  state;
`ifdef CPU_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cyc = 0;
  logic [31:0] exp_ret = 0;

  typedef enum int {C_OP, C_OPIMM, C_LOAD, C_STORE, C_BR, C_JAL, C_EBREAK, C_ILL} cls_t;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.DATAWIDTH(32), .RESET_HALT(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .instr_i(instr), .eq_i(eq), .lt_i(lt),
    .imem_re_o(imem_re), .ir_en_o(ir_en), .rf_re_o(rf_re), .rf_we_o(rf_we),
    .wb_sel_o(wb_sel), .alu_op_o(alu_op), .alu_b_imm_o(alu_b_imm),
    .dmem_re_o(dmem_re), .dmem_we_o(dmem_we), .pc_en_o(pc_en), .pc_sel_o(pc_sel),
    .halt_o(halt), .illegal_o(illegal), .state_o(state)
`ifdef CPU_CTRL_PERF_EN
    , .cycle_cnt_o(cycle_cnt), .instret_cnt_o(instret_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cls_t classify(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return C_OP;
      7'b0010011: return C_OPIMM;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return (w[14:12] inside {3'd0, 3'd1, 3'd4, 3'd5}) ? C_BR : C_ILL;
      7'b1101111: return C_JAL;
      7'b1110011: return (w == 32'h0010_0073) ? C_EBREAK : C_ILL;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr(input int k);
    logic [31:0] w;
    logic [6:0]  bad [5];
    logic [2:0]  bf3 [4];
    logic [2:0]  xf3 [4];
    bad = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b0010111, 7'b1100111};
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5};
    xf3 = '{3'd2, 3'd3, 3'd6, 3'd7};
    w = $urandom;
    case (k)
      0: w[6:0] = 7'b0110011;
      1: w[6:0] = 7'b0010011;
      2: w[6:0] = 7'b0000011;
      3: w[6:0] = 7'b0100011;
      4: begin w[6:0] = 7'b1100011; w[14:12] = bf3[$urandom_range(0, 3)]; end
      5: w[6:0] = 7'b1101111;
      6: w = 32'h0010_0073;
      7: w[6:0] = bad[$urandom_range(0, 4)];
      8: begin w[6:0] = 7'b1100011; w[14:12] = xf3[$urandom_range(0, 3)]; end
      default: begin
        w[6:0] = 7'b1110011;
        if (w == 32'h0010_0073) w[31] = 1'b1;
      end
    endcase
    if ((k <= 5) && ($urandom_range(0, 3) == 0)) w[11:7] = 5'd0;
    return w;
  endfunction

  // Runs one instruction starting in a FETCH cycle and compares against the model
  task automatic run_instr(input logic [31:0] w, input logic e, input logic l);
    cls_t        cls;
    logic [63:0] exp_seq, got_seq;
    logic        halts, exp_taken, exp_pcsel, exp_alu_chk, exp_bimm;
    logic [1:0]  exp_wbsel;
    logic [3:0]  exp_alu;
    int          exp_pcen, exp_rfwe, exp_dre, exp_dwe, ncyc;
    int          n_pcen, n_rfwe, n_dre, n_dwe, n_ire;
    logic        got_pcsel;
    logic [1:0]  got_wbsel;
    cls = classify(w);
    halts = (cls == C_EBREAK) || (cls == C_ILL);
    case (w[14:12])
      3'd0:    exp_taken = e;
      3'd1:    exp_taken = !e;
      3'd4:    exp_taken = l;
      default: exp_taken = !l;
    endcase
    case (cls)
      C_OP, C_OPIMM, C_JAL: begin exp_seq = 64'h12351; ncyc = 4; end
      C_LOAD:               begin exp_seq = 64'h123451; ncyc = 5; end
      C_STORE:              begin exp_seq = 64'h12341; ncyc = 4; end
      C_BR:                 begin exp_seq = 64'h1231; ncyc = 3; end
      default:              begin exp_seq = 64'h1236; ncyc = 3; end
    endcase
    exp_pcen  = halts ? 0 : 1;
    exp_pcsel = (cls == C_BR) ? exp_taken : (cls == C_JAL);
    exp_wbsel = (cls == C_LOAD) ? 2'b01 : (cls == C_JAL) ? 2'b10 : 2'b00;
    exp_rfwe  = ((cls inside {C_OP, C_OPIMM, C_LOAD, C_JAL}) && (w[11:7] != 5'd0)) ? 1 : 0;
    exp_dre   = (cls == C_LOAD) ? 1 : 0;
    exp_dwe   = (cls == C_STORE) ? 1 : 0;
    exp_alu_chk = cls inside {C_OP, C_OPIMM, C_LOAD, C_STORE, C_JAL};
    exp_alu   = (cls == C_OP) ? {w[30], w[14:12]} :
                (cls == C_OPIMM) ? {(w[14:12] == 3'd5) && w[30], w[14:12]} : 4'd0;
    exp_bimm  = (cls != C_OP);
    got_seq = 0; n_pcen = 0; n_rfwe = 0; n_dre = 0; n_dwe = 0; n_ire = 0;
    got_pcsel = 1'b0; got_wbsel = 2'b00;
    for (int c = 0; c < 8; c++) begin
      instr = (c == 1) ? w : $urandom;
      eq = e; lt = l; run = 1'($urandom);
      #1;
      got_seq = (got_seq << 4) | 64'(state + 3'd1);
      checks++;
      if (int'(imem_re) + int'(dmem_re) + int'(dmem_we) > 1) begin
        errors++; $display("FAIL mem_exclusive instr=%08h cycle=%0d got imem=%b dre=%b dwe=%b expected at most one", w, c, imem_re, dmem_re, dmem_we);
      end
`ifdef CPU_CTRL_PERF_EN
      if (c == 0) begin
        checks++;
        if (cycle_cnt !== exp_cyc || instret_cnt !== exp_ret) begin
          errors++; $display("FAIL perf_counters got cyc=%0d ret=%0d expected cyc=%0d ret=%0d", cycle_cnt, instret_cnt, exp_cyc, exp_ret);
        end
      end
`endif
      if (c == 1) begin
        checks++;
        if (ir_en !== 1'b1 || rf_re !== 1'b1) begin
          errors++; $display("FAIL decode_en instr=%08h got ir_en=%b rf_re=%b expected 1 1", w, ir_en, rf_re);
        end
      end
      if (c == 2 && exp_alu_chk) begin
        checks++;
        if (alu_op !== exp_alu || alu_b_imm !== exp_bimm) begin
          errors++; $display("FAIL exec_alu instr=%08h got op=%b imm=%b expected op=%b imm=%b", w, alu_op, alu_b_imm, exp_alu, exp_bimm);
        end
      end
      if (imem_re) n_ire++;
      if (rf_we) n_rfwe++;
      if (dmem_re) n_dre++;
      if (dmem_we) n_dwe++;
      if (pc_en) begin n_pcen++; got_pcsel = pc_sel; got_wbsel = wb_sel; end
      tick();
      if (state == 3'd0 || state == 3'd5) break;
    end
    got_seq = (got_seq << 4) | 64'(state + 3'd1);
    checks++;
    if (got_seq !== exp_seq) begin
      errors++; $display("FAIL state_seq instr=%08h got %0h expected %0h", w, got_seq, exp_seq);
    end
    checks++;
    if (n_pcen !== exp_pcen || n_ire !== 1) begin
      errors++; $display("FAIL pc_en_count instr=%08h got pc_en=%0d imem_re=%0d expected %0d 1", w, n_pcen, n_ire, exp_pcen);
    end
    if (exp_pcen == 1) begin
      checks++;
      if (got_pcsel !== exp_pcsel || got_wbsel !== exp_wbsel) begin
        errors++; $display("FAIL pc_wb_sel instr=%08h eq=%b lt=%b got sel=%b wb=%b expected sel=%b wb=%b", w, e, l, got_pcsel, got_wbsel, exp_pcsel, exp_wbsel);
      end
    end
    checks++;
    if (n_rfwe !== exp_rfwe || n_dre !== exp_dre || n_dwe !== exp_dwe) begin
      errors++; $display("FAIL we_counts instr=%08h got rf_we=%0d dre=%0d dwe=%0d expected %0d %0d %0d", w, n_rfwe, n_dre, n_dwe, exp_rfwe, exp_dre, exp_dwe);
    end
    checks++;
    if (halt !== halts || illegal !== (cls == C_ILL)) begin
      errors++; $display("FAIL end_flags instr=%08h got halt=%b illegal=%b expected %b %b", w, halt, illegal, halts, cls == C_ILL);
    end
    exp_cyc = exp_cyc + 32'(ncyc);
    exp_ret = exp_ret + 32'(exp_pcen);
    if (halts) resume();
  endtask

  // Sits in HALT, checks run_i=0 holds it, then pulses run_i
  task automatic resume();
    run = 1'b0;
    tick();
    tick();
    checks++;
    if (state !== 3'd5 || halt !== 1'b1 || pc_en !== 1'b0 || imem_re !== 1'b0) begin
      errors++; $display("FAIL halt_hold got state=%0d halt=%b pc_en=%b imem_re=%b expected 5 1 0 0", state, halt, pc_en, imem_re);
    end
`ifdef CPU_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== exp_cyc || instret_cnt !== exp_ret) begin
      errors++; $display("FAIL perf_hold got cyc=%0d ret=%0d expected %0d %0d", cycle_cnt, instret_cnt, exp_cyc, exp_ret);
    end
`endif
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0 || halt !== 1'b0 || imem_re !== 1'b1) begin
      errors++; $display("FAIL resume got state=%0d illegal=%b halt=%b imem_re=%b expected 0 0 0 1", state, illegal, halt, imem_re);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; instr = '0; eq = 1'b0; lt = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_re, ir_en, rf_re, rf_we, dmem_re, dmem_we, pc_en, pc_sel, alu_b_imm, wb_sel, alu_op} !== '0
          || state !== 3'd0 || halt !== 1'b0 || illegal !== 1'b0) begin
        errors++; $display("FAIL reset_outputs cycle=%0d got state=%0d imem_re=%b halt=%b illegal=%b expected all zero", i, state, imem_re, halt, illegal);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || imem_re !== 1'b1) begin
      errors++; $display("FAIL reset_release got state=%0d imem_re=%b expected 0 1", state, imem_re);
    end
    exp_cyc = 0;
    exp_ret = 0;
  endtask

  task automatic test_directed();
    run_instr(32'h0020_81B3, 1'b0, 1'b0);
    run_instr(32'h0000_A183, 1'b0, 1'b0);
    run_instr(32'h0030_A023, 1'b0, 1'b0);
    run_instr(32'h0020_8463, 1'b1, 1'b0);
    run_instr(32'h0020_8463, 1'b0, 1'b1);
    run_instr(32'hFFFF_FFFF, 1'b0, 1'b0);
    run_instr(32'h0010_0073, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      run_instr(gen_instr($urandom_range(0, 9)), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset_mid_store();
    instr = $urandom;
    tick();
    instr = 32'h0030_A023;
    tick();
    instr = $urandom;
    tick();
    checks++;
    if (dmem_we !== 1'b1 || state !== 3'd3) begin
      errors++; $display("FAIL store_mem got dmem_we=%b state=%0d expected 1 3", dmem_we, state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dmem_we !== 1'b0 || pc_en !== 1'b0 || rf_we !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL reset_abort got dmem_we=%b pc_en=%b rf_we=%b state=%0d expected 0 0 0 0", dmem_we, pc_en, rf_we, state);
    end
`ifdef CPU_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_reset got cyc=%0d ret=%0d expected 0 0", cycle_cnt, instret_cnt);
    end
`endif
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || imem_re !== 1'b1) begin
      errors++; $display("FAIL abort_release got state=%0d imem_re=%b expected 0 1", state, imem_re);
    end
    exp_cyc = 0;
    exp_ret = 0;
    run_instr(32'h0000_A183, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
